// File: rtl/hazard_pkg.sv
// ----------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the pipeline hazard unit.
//   hz_state_t  : hazard FSM state encoding (RUN, LOAD_STALL, MEM_WAIT, FLUSH)
//   REG_ADDR_W  : width of a register-file address
//   REG_ZERO    : address of the hard-wired zero register (x0)
//   STAT_W      : width of the optional statistics counters
// ----------------------------------------------------------------------------
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        HZ_RUN        = 2'd0,
        HZ_LOAD_STALL = 2'd1,
        HZ_MEM_WAIT   = 2'd2,
        HZ_FLUSH      = 2'd3
    } hz_state_t;

endpackage

// File: rtl/hazard_cmp.sv
// ----------------------------------------------------------------------------
// hazard_cmp
// Combinational load-use detector. Flags when the instruction in EX is a load
// whose destination register is read by the instruction in ID.
// Ports:
//   rs1, rs2    : source registers of the instruction in ID
//   rd_ex       : destination register of the instruction in EX
//   ex_memread  : instruction in EX is a load
//   load_use    : load-use hazard present this cycle
// ----------------------------------------------------------------------------
module hazard_cmp
    import hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  ex_memread,
    output logic                  load_use
);

    // x0 is never really written, so a load targeting it cannot create a hazard.
    assign load_use = ex_memread
                    && (rd_ex != REG_ZERO)
                    && ((rd_ex == rs1) || (rd_ex == rs2));

endmodule

// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard controller: load-use stalls, data-memory wait stalls and
// taken-branch flushes, arbitrated by a small Mealy FSM.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   Registro1/2         : rs1/rs2 of the instruction in ID
//   Rd_execute          : rd of the instruction in EX
//   ex_memread          : instruction in EX is a load
//   branch_taken        : branch/jump resolved taken in EX
//   mem_req, mem_ready  : data-memory access in MEM and its completion
//   stall_pc/ifid/exmem : hold controls for PC, IF/ID, ID/EX + EX/MEM
//   flush_ifid/idex     : NOP insertion into IF/ID, ID/EX
//   hazard_state        : current FSM state
//   stall_cycles, flush_events : statistics counters, present only when
//                        the macro HAZARD_STATS_EN is defined
// ----------------------------------------------------------------------------
module hazard_unit
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] Registro1,
    input  logic [REG_ADDR_W-1:0] Registro2,
    input  logic [REG_ADDR_W-1:0] Rd_execute,
    input  logic                  ex_memread,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  stall_pc,
    output logic                  stall_ifid,
    output logic                  stall_exmem,
    output logic                  flush_ifid,
    output logic                  flush_idex,
    output logic [1:0]            hazard_state
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0]     stall_cycles,
    output logic [STAT_W-1:0]     flush_events
`endif
);

    hz_state_t state_q, state_d;
    logic      pending_q, pending_d;
    logic      load_use;
    logic      mem_wait;

    logic stall_pc_c, stall_ifid_c, stall_exmem_c, flush_ifid_c, flush_idex_c;

    hazard_cmp u_cmp (
        .rs1        (Registro1),
        .rs2        (Registro2),
        .rd_ex      (Rd_execute),
        .ex_memread (ex_memread),
        .load_use   (load_use)
    );

    assign mem_wait = mem_req && !mem_ready;

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        stall_pc_c    = 1'b0;
        stall_ifid_c  = 1'b0;
        stall_exmem_c = 1'b0;
        flush_ifid_c  = 1'b0;
        flush_idex_c  = 1'b0;

        case (state_q)
            HZ_RUN, HZ_LOAD_STALL: begin
                if (mem_wait) begin
                    stall_pc_c    = 1'b1;
                    stall_ifid_c  = 1'b1;
                    stall_exmem_c = 1'b1;
                    state_d       = HZ_MEM_WAIT;
                end else if (branch_taken) begin
                    flush_ifid_c  = 1'b1;
                    flush_idex_c  = 1'b1;
                    state_d       = HZ_FLUSH;
                end else if (load_use && (state_q == HZ_RUN)) begin
                    // The stall cycle itself resolves the hazard, so it is
                    // masked in LOAD_STALL to avoid stalling twice.
                    stall_pc_c    = 1'b1;
                    stall_ifid_c  = 1'b1;
                    flush_idex_c  = 1'b1;
                    state_d       = HZ_LOAD_STALL;
                end else begin
                    state_d       = HZ_RUN;
                end
            end

            HZ_MEM_WAIT: begin
                if (!mem_ready) begin
                    stall_pc_c    = 1'b1;
                    stall_ifid_c  = 1'b1;
                    stall_exmem_c = 1'b1;
                    if (branch_taken) begin
                        pending_d = 1'b1;
                    end
                end else begin
                    // A branch remembered during the wait (or resolving on the
                    // ready cycle) is flushed as soon as the pipeline moves.
                    pending_d = 1'b0;
                    if (pending_q || branch_taken) begin
                        flush_ifid_c = 1'b1;
                        flush_idex_c = 1'b1;
                        state_d      = HZ_FLUSH;
                    end else begin
                        state_d      = HZ_RUN;
                    end
                end
            end

            HZ_FLUSH: begin
                // Second wrong-path fetch slot.
                flush_ifid_c = 1'b1;
                state_d      = HZ_RUN;
            end

            default: begin
                state_d   = HZ_RUN;
                pending_d = 1'b0;
            end
        endcase

        // Holding ID/EX takes precedence over bubbling it.
        if (stall_exmem_c) begin
            flush_idex_c = 1'b0;
        end
    end

    // Outputs are forced low while reset is asserted, independent of inputs.
    assign stall_pc     = rst_n && stall_pc_c;
    assign stall_ifid   = rst_n && stall_ifid_c;
    assign stall_exmem  = rst_n && stall_exmem_c;
    assign flush_ifid   = rst_n && flush_ifid_c;
    assign flush_idex   = rst_n && flush_idex_c;
    assign hazard_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HZ_RUN;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_pc && (stall_cnt_q != {STAT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        // Only flushes entered from RUN/LOAD_STALL are counted; a flush that
        // follows a memory wait is not a new RUN-side event.
        if (((state_q == HZ_RUN) || (state_q == HZ_LOAD_STALL))
            && (state_d == HZ_FLUSH)
            && (flush_cnt_q != {STAT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_hazard_unit
// Self-checking bench for hazard_unit: a table of per-cycle vectors with
// hand-computed outputs and state, followed by an asynchronous-reset sequence.
// Statistics counters are checked when HAZARD_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] Registro1, Registro2, Rd_execute;
    logic       ex_memread, branch_taken, mem_req, mem_ready;
    logic       stall_pc, stall_ifid, stall_exmem, flush_ifid, flush_idex;
    logic [1:0] hazard_state;
`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cycles, flush_events;
`endif

    int checks = 0;
    int errors = 0;

    hazard_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Registro1    (Registro1),
        .Registro2    (Registro2),
        .Rd_execute   (Rd_execute),
        .ex_memread   (ex_memread),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .stall_pc     (stall_pc),
        .stall_ifid   (stall_ifid),
        .stall_exmem  (stall_exmem),
        .flush_ifid   (flush_ifid),
        .flush_idex   (flush_idex),
        .hazard_state (hazard_state)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output bits, MSB first: stall_pc, stall_ifid, stall_exmem,
    // flush_ifid, flush_idex.
    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       memread;
        logic       branch;
        logic       mreq;
        logic       mready;
        logic [4:0] exp_out;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic memread,
                          input logic branch, input logic mreq,
                          input logic mready, input logic [4:0] exp_out,
                          input logic [1:0] exp_state);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.memread = memread;
        v.branch = branch; v.mreq = mreq; v.mready = mready;
        v.exp_out = exp_out; v.exp_state = exp_state;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        Registro1    = v.rs1;
        Registro2    = v.rs2;
        Rd_execute   = v.rd;
        ex_memread   = v.memread;
        branch_taken = v.branch;
        mem_req      = v.mreq;
        mem_ready    = v.mready;
    endtask

    task automatic checkOutput(input string name, input logic [4:0] exp_out,
                               input logic [1:0] exp_state);
        logic [4:0] act;
        act = {stall_pc, stall_ifid, stall_exmem, flush_ifid, flush_idex};
        checks++;
        if (act !== exp_out) begin
            errors++;
            $display("[TB] FAIL %s outputs: got %b expected %b", name, act, exp_out);
        end
        checks++;
        if (hazard_state !== exp_state) begin
            errors++;
            $display("[TB] FAIL %s state: got %0d expected %0d", name, hazard_state, exp_state);
        end
    endtask

    task automatic checkValue(input string name, input logic [15:0] act,
                              input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        vec_t idle;
        //     rs1    rs2    rd     mr    br    mreq  mrdy  P I X F D   st
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0); // 0 idle
        addVec(5'd3,  5'd5,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 5'b11001, 2'd0); // 1 load-use rs1
        addVec(5'd3,  5'd5,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd1); // 2 LOAD_STALL masks
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0); // 3 back to RUN
        addVec(5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0); // 4 x0 guard
        addVec(5'd1,  5'd7,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, 5'b11001, 2'd0); // 5 load-use rs2
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 5'b00011, 2'd1); // 6 branch in LOAD_STALL
        addVec(5'd4,  5'd0,  5'd4,  1'b1, 1'b0, 1'b0, 1'b0, 5'b00010, 2'd3); // 7 FLUSH ignores load-use
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0); // 8
        addVec(5'd8,  5'd10, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0); // 9 no reg match
        addVec(5'd9,  5'd0,  5'd9,  1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0); // 10 not a load
        addVec(5'd2,  5'd0,  5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 5'b00011, 2'd0); // 11 branch beats load-use
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'b00010, 2'd3); // 12 FLUSH
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'b11100, 2'd0); // 13 mem wait 1
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'b11100, 2'd2); // 14 mem wait 2
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'b11100, 2'd2); // 15 mem wait 3
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 2'd2); // 16 ready
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0); // 17
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'b11100, 2'd0); // 18 wait starts
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 5'b11100, 2'd2); // 19 1st MEM_WAIT
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 5'b11100, 2'd2); // 20 branch in 2nd
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'b00011, 2'd2); // 21 ready: flush
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'b00010, 2'd3); // 22 FLUSH
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0); // 23
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 2'd0); // 24 ready at once
        addVec(5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 2'd0); // 25

        // Reset asserted with a memory wait pending on the inputs: outputs
        // must still be gated off.
        rst_n        = 1'b0;
        Registro1    = 5'd0;
        Registro2    = 5'd0;
        Rd_execute   = 5'd0;
        ex_memread   = 1'b0;
        branch_taken = 1'b0;
        mem_req      = 1'b1;
        mem_ready    = 1'b0;
        #3;
        checkOutput("reset_hold", 5'b00000, 2'd0);
`ifdef HAZARD_STATS_EN
        checkValue("reset_stall_cycles", stall_cycles, 16'd0);
        checkValue("reset_flush_events", flush_events, 16'd0);
`endif
        @(negedge clk);
        rst_n   = 1'b1;
        mem_req = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_state);
        end

`ifdef HAZARD_STATS_EN
        checkValue("stall_cycles", stall_cycles, 16'd8);
        checkValue("flush_events", flush_events, 16'd2);
`endif

        // Asynchronous reset in the middle of a MEM_WAIT cycle.
        idle = vecs[0];
        idle.mreq = 1'b1;
        applyStimulus(idle);
        #2;
        checkOutput("async_wait_enter", 5'b11100, 2'd0);
        @(posedge clk);
        #2;
        checkOutput("async_in_wait", 5'b11100, 2'd2);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 5'b00000, 2'd0);
`ifdef HAZARD_STATS_EN
        checkValue("async_stall_cycles", stall_cycles, 16'd0);
`endif

        // First edge after release evaluates from RUN.
        @(negedge clk);
        rst_n        = 1'b1;
        mem_req      = 1'b0;
        Registro1    = 5'd6;
        Rd_execute   = 5'd6;
        ex_memread   = 1'b1;
        #2;
        checkOutput("release_loaduse", 5'b11001, 2'd0);
        @(negedge clk);
        ex_memread   = 1'b0;
        #2;
        checkOutput("release_loadstall", 5'b00000, 2'd1);
        @(negedge clk);
        #2;
        checkOutput("release_run", 5'b00000, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
